// File: rtl/conv_axis_serializer_pkg.sv
// conv_axis_serializer_pkg: shared widths and helpers for the serializer and maxpool stream
package conv_axis_serializer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CONV_UNITS = 8;
    localparam int DEF_CONV_CORES = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_w(input int units);
        return units > 1 ? clog2(units) : 1;
    endfunction

    localparam int DEF_SW    = DEF_DATA_WIDTH * DEF_CONV_CORES;
    localparam int DEF_IDX_W = idx_w(DEF_CONV_UNITS);

endpackage

// File: rtl/conv_axis_serializer_if.sv
// conv_axis_serializer_if: AXI-stream bundle with master/slave views
interface conv_axis_serializer_if
    import conv_axis_serializer_pkg::*;
#(
    parameter int W = DEF_SW
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/conv_axis_serializer.sv
// conv_axis_serializer: replays one wide beat as CONV_UNITS narrow beats
module conv_axis_serializer
    import conv_axis_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CONV_UNITS = DEF_CONV_UNITS,
    parameter int CONV_CORES = DEF_CONV_CORES
) (
    input logic                    aclk,
    input logic                    areset,
    conv_axis_serializer_if.slave  s_axis,
    conv_axis_serializer_if.master m_axis
);

    localparam int SW = DATA_WIDTH * CONV_CORES;
    localparam int IDX_W = idx_w(CONV_UNITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CONV_UNITS - 1);

    logic                   full_r;
    logic                   last_r;
    logic [SW*CONV_UNITS-1:0] data_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   at_end;
    logic                   accept;

    // a new wide beat may land in the same cycle the final slice leaves
    always_comb begin
        at_end        = idx_r == LAST;
        s_axis.tready = !full_r || (at_end && m_axis.tready);
        accept        = s_axis.tvalid && s_axis.tready;
        m_axis.tvalid = full_r;
        m_axis.tdata  = data_r[SW*int'(idx_r) +: SW];
        m_axis.tlast  = last_r && at_end;
    end

    // holding register and slice counter
    always_ff @(posedge aclk) begin
        if (areset) begin
            full_r <= 1'b0;
            last_r <= 1'b0;
            data_r <= '0;
            idx_r  <= '0;
        end else if (accept) begin
            full_r <= 1'b1;
            last_r <= s_axis.tlast;
            data_r <= s_axis.tdata;
            idx_r  <= '0;
        end else if (full_r && m_axis.tready) begin
            full_r <= !at_end;
            idx_r  <= at_end ? '0 : idx_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_axis_serializer.sv
// tb_conv_axis_serializer: scoreboard and vector checks for two serializer configurations
module tb_conv_axis_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_axis_serializer_if #(.W(128)) s0 ();
    conv_axis_serializer_if #(.W(16))  m0 ();
    conv_axis_serializer_if #(.W(32))  s1 ();
    conv_axis_serializer_if #(.W(32))  m1 ();

    conv_axis_serializer #(.DATA_WIDTH(16), .CONV_UNITS(8), .CONV_CORES(1)) dut0 (
        .aclk(clk), .areset(rst), .s_axis(s0.slave), .m_axis(m0.master)
    );

    conv_axis_serializer #(.DATA_WIDTH(16), .CONV_UNITS(1), .CONV_CORES(2)) dut1 (
        .aclk(clk), .areset(rst), .s_axis(s1.slave), .m_axis(m1.master)
    );

    int total = 0;
    int bad = 0;
    logic [16:0] q[$];
    int cyc = 0, vcnt = 0, lcnt = 0, hcnt = 0, first_c = 0, last_c = 0;
    logic pend = 1'b0;
    logic [15:0] pd;
    logic pl;
    bit done;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic        sr;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] base);
        logic [127:0] r;
        for (int u = 0; u < 8; u++) r[u*16 +: 16] = base + 16'(u);
        return r;
    endfunction

    task automatic send0(input logic [127:0] d, input logic l);
        bit got;
        got = 0;
        s0.tvalid = 1'b1;
        s0.tdata  = d;
        s0.tlast  = l;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = s0.tready;
            @(posedge clk);
            #1;
        end
        s0.tvalid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no tready want tready within 200 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || m0.tvalid) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_left", 128'(q.size()), 0);
        chk("drain_valid", m0.tvalid, 0);
    endtask

    task automatic clr();
        vcnt = 0;
        lcnt = 0;
        hcnt = 0;
    endtask

    // scoreboard: push slices on accept, pop on handshake, watch stalls
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("stall_valid", m0.tvalid, 1);
                chk("stall_data", m0.tdata, pd);
                chk("stall_last", m0.tlast, pl);
            end
            if (s0.tvalid && s0.tready)
                for (int u = 0; u < 8; u++) q.push_back({u == 7 ? s0.tlast : 1'b0, s0.tdata[u*16 +: 16]});
            if (m0.tvalid) begin
                vcnt++;
                if (vcnt == 1) first_c = cyc;
                last_c = cyc;
            end
            if (m0.tvalid && m0.tready) begin
                hcnt++;
                if (m0.tlast) lcnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0h want no beat", m0.tdata);
                end else begin
                    logic [16:0] e;
                    e = q.pop_front();
                    chk("beat_data", m0.tdata, e[15:0]);
                    chk("beat_last", m0.tlast, e[16]);
                    if (e[16]) chk("final_sready", s0.tready, 1);
                end
            end
            pend = m0.tvalid && !m0.tready;
            pd = m0.tdata;
            pl = m0.tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 32'h1111_0001, 1'b0, 1'b1,  1'b0, 32'h0,         1'b0, 1'b1};
        vt[1] = '{1'b1, 32'h2222_0002, 1'b1, 1'b1,  1'b1, 32'h1111_0001, 1'b0, 1'b1};
        vt[2] = '{1'b1, 32'h3333_0003, 1'b0, 1'b0,  1'b1, 32'h2222_0002, 1'b1, 1'b0};
        vt[3] = '{1'b1, 32'h4444_0004, 1'b1, 1'b0,  1'b1, 32'h2222_0002, 1'b1, 1'b0};
        vt[4] = '{1'b1, 32'h4444_0004, 1'b0, 1'b1,  1'b1, 32'h2222_0002, 1'b1, 1'b1};
        vt[5] = '{1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 32'h4444_0004, 1'b0, 1'b1};
        vt[6] = '{1'b0, 32'h0,         1'b0, 1'b0,  1'b0, 32'h4444_0004, 1'b0, 1'b1};
        vt[7] = '{1'b1, 32'h5555_0005, 1'b1, 1'b0,  1'b0, 32'h4444_0004, 1'b0, 1'b1};
        vt[8] = '{1'b0, 32'h0,         1'b0, 1'b0,  1'b1, 32'h5555_0005, 1'b1, 1'b0};
        vt[9] = '{1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 32'h5555_0005, 1'b1, 1'b1};

        s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0; m0.tready = 1'b1;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0; m1.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", m0.tvalid, 0);
        chk("rst_data", m0.tdata, 0);
        chk("rst_last", m0.tlast, 0);
        chk("rst_sready", s0.tready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            s1.tvalid = vt[i].sv;
            s1.tdata  = vt[i].sd;
            s1.tlast  = vt[i].sl;
            m1.tready = vt[i].mr;
            @(negedge clk);
            chk($sformatf("u1_valid[%0d]", i), m1.tvalid, vt[i].mv);
            chk($sformatf("u1_data[%0d]", i), m1.tdata, vt[i].md);
            chk($sformatf("u1_last[%0d]", i), m1.tlast, vt[i].ml);
            chk($sformatf("u1_sready[%0d]", i), s1.tready, vt[i].sr);
            @(posedge clk);
            #1;
        end
        s1.tvalid = 1'b0;

        clr();
        send0(mk(16'h0100), 1'b1);
        drain();
        chk("one_count", vcnt, 8);
        chk("one_span", last_c - first_c + 1, 8);
        chk("one_tlast", lcnt, 1);

        clr();
        send0(mk(16'h0200), 1'b0);
        send0(mk(16'h0300), 1'b0);
        send0(mk(16'h0400), 1'b1);
        drain();
        chk("b2b_count", vcnt, 24);
        chk("b2b_span", last_c - first_c + 1, 24);
        chk("b2b_tlast", lcnt, 1);

        clr();
        done = 0;
        fork
            begin
                for (int k = 0; k < 100; k++)
                    send0({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 m0.tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m0.tready = 1'b1;
        drain();
        chk("rand_beats", hcnt, 800);

        send0(mk(16'h0500), 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", m0.tvalid, 0);
        chk("mid_rst_data", m0.tdata, 0);
        chk("mid_rst_last", m0.tlast, 0);
        chk("mid_rst_sready", s0.tready, 1);
        @(posedge clk);
        #1;
        clr();
        send0(mk(16'h0600), 1'b1);
        drain();
        chk("post_rst_beats", hcnt, 8);

        m0.tready = 1'b0;
        send0(mk(16'h0700), 1'b0);
        s0.tvalid = 1'b1;
        s0.tdata  = mk(16'h0800);
        s0.tlast  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_sready", s0.tready, 0);
            chk("hold_valid", m0.tvalid, 1);
            @(posedge clk);
            #1;
        end
        m0.tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("hold_release[%0d]", j), s0.tready, j == 7);
            @(posedge clk);
            #1;
        end
        s0.tvalid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_axis_serializer.md
# conv_axis_serializer

Upstream neighbour of the maxpool AXI-stream stage. Accepts one wide beat holding all CONV_UNITS results for every core, and replays it as CONV_UNITS narrow beats of DATA_WIDTH*CONV_CORES bits. This matches the per-beat format the maxpool stage consumes. A single holding register is used, so sustained throughput is one wide beat per CONV_UNITS cycles with no bubbles; packet boundaries travel on tlast.

## Interface
- DATA_WIDTH, 16, bits per result
- CONV_UNITS, 8, sub-beats per wide beat (≥1)
- CONV_CORES, 1, cores packed side by side in each sub-beat
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  wide beat valid
- s_axis_tready  out  1  wide beat accepted when high with tvalid
- s_axis_tdata  in  DATA_WIDTH*CONV_CORES*CONV_UNITS  wide beat
- s_axis_tlast  in  1  wide beat ends packet
- m_axis_tvalid  out  1  narrow beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_WIDTH*CONV_CORES  narrow beat
- m_axis_tlast  out  1  last narrow beat of packet

## Operation
- Let SW = DATA_WIDTH*CONV_CORES. Slice u of s_axis_tdata occupies bits [(u+1)*SW-1 : u*SW]. Within a slice, core c sits at [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH], unchanged.
- State:
  - full_r: holding register occupied.
  - data_r: wide word.
  - last_r: captured tlast.
  - idx_r: current slice. Width max(1,clog2(CONV_UNITS)).
- Output mapping:
  - m_axis_tvalid = full_r.
  - m_axis_tdata = slice idx_r of data_r.
  - m_axis_tlast = last_r && (idx_r == CONV_UNITS-1).
- Accept: s_axis_tready = !full_r || (idx_r == CONV_UNITS-1 && m_axis_tready). This is a combinational path from m_axis_tready.
- On accept: data_r and last_r load from input, full_r=1, idx_r=0.
- On output handshake (m_axis_tvalid && m_axis_tready):
  - idx_r < CONV_UNITS-1: idx_r increments.
  - idx_r == CONV_UNITS-1 with no simultaneous accept: full_r=0, idx_r=0.
  - idx_r == CONV_UNITS-1 with simultaneous accept: the new beat loads as above. Zero-bubble handoff.
- Stall: m_axis_tready low holds idx_r, data_r and all outputs stable. AXI rule: once valid, it stays valid until the handshake.
- tlast on an input beat only flags its final narrow beat. Inputs without tlast never raise m_axis_tlast.
- CONV_UNITS=1: idx_r is tied to 0 and the block behaves as a one-deep register slice.
- Sequence: empty → (accept) → streaming idx 0..CONV_UNITS-1 → empty, or straight back to streaming idx 0 on a simultaneous accept.

## Timing
- Reset values: full_r=0, idx_r=0, last_r=0, data_r=0. Hence m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and s_axis_tready=1 from the first cycle after reset.
- Reset mid-stream discards the held beat and any remaining slices. No partial tail is emitted after reset.
- Latency: a wide beat accepted at edge N presents slice 0 after edge N. Slice k is presented after edge N+k when m_axis_tready is held high.
- Throughput: one wide beat per CONV_UNITS cycles with no bubbles, given back-to-back input and continuous downstream ready.
- Input tdata and tlast are sampled only on accept. Changes while s_axis_tready is low are ignored.

## Structure
- Shared package/header:
  - clog2 function.
  - Derived width constants: SW = DATA_WIDTH*CONV_CORES, IDX_W = max(1,clog2(CONV_UNITS)). These are also used by the maxpool stage's stream width.
- Single module, no sub-module. The slice mux is an indexed part-select on data_r. The counter and flags are inline.
- Ports use the AXI-stream names above so the block wires directly to the maxpool stage's slave port.

## Test plan
- Defaults, one wide beat with slice u = {CONV_CORES copies of 16'h0100+u}, tlast=1, m_axis_tready=1 → eight beats 16'h0100..16'h0107 on consecutive cycles; tlast only on 16'h0107; s_axis_tready high in that same cycle.
- Three back-to-back wide beats, tlast on the third, ready always high → 24 contiguous m_axis_tvalid cycles; exactly one tlast, on beat 24; no bubbles.
- Random m_axis_tready (50%) over 100 beats → output equals the reference slice order; tdata, tlast and tvalid stable during every stall; no drops or duplicates.
- areset pulsed after slice 3 of a held beat → next cycle m_axis_tvalid=0 and tdata=0; the next accepted beat starts at slice 0; no stale slices appear.
- CONV_UNITS=1, CONV_CORES=2 → each input emitted one cycle later unchanged, tlast passed through, full rate.
- Input tvalid asserted while full with m_axis_tready low → s_axis_tready stays 0; the input is held by the source and accepted only in the cycle the final slice handshakes.
